// File: rtl/minesweeper_game_ctrl.sv
// minesweeper_game_ctrl: game sequencing for the 8x8 minesweeper board
// clk, reset (sync, active-low); mine_in: mine layout, latched on COUNT entry
// start: restart from LOST/WON; mv_*/step/flag: single-cycle player pulses
// mineMap/flagMap/stepMap/posMap: board maps for the renderer
// state: 0 COUNT, 1 PLAY, 2 REVEAL, 3 LOST, 4 WON; safe_left: safe tiles still hidden
// won/lost: registered end-of-game flags
module minesweeper_game_ctrl #(
    parameter logic [5:0] START_TILE = 6'd0,
    parameter logic [5:0] SCAN_LAST  = 6'd63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] mine_in,
    input  logic        start,
    input  logic        mv_up,
    input  logic        mv_down,
    input  logic        mv_left,
    input  logic        mv_right,
    input  logic        step,
    input  logic        flag,
    output logic [63:0] mineMap,
    output logic [63:0] flagMap,
    output logic [63:0] stepMap,
    output logic [63:0] posMap,
    output logic [2:0]  state,
    output logic [6:0]  safe_left,
    output logic        won,
    output logic        lost
);
    localparam logic [2:0] S_COUNT = 3'd0, S_PLAY = 3'd1, S_REVEAL = 3'd2, S_LOST = 3'd3, S_WON = 3'd4;
    logic [2:0]  state_nx;
    logic [5:0]  idx, idx_nx, cursor, cursor_nx;
    logic [6:0]  cnt, cnt_nx, cnt_total, safe_nx;
    logic        loaded, loaded_nx, step_ok;
    logic [63:0] mine_nx, flag_nx, step_nx;
    // first COUNT cycle only latches mine_in; the scan runs once loaded is set
    assign cnt_total = cnt + {6'd0, mineMap[idx]};
    assign step_ok   = !flagMap[cursor] && !stepMap[cursor];
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_COUNT;
            idx       <= 6'd0;
            cnt       <= 7'd0;
            loaded    <= 1'b0;
            cursor    <= START_TILE;
            safe_left <= 7'd0;
            mineMap   <= 64'd0;
            flagMap   <= 64'd0;
            stepMap   <= 64'd0;
            posMap    <= 64'd1 << START_TILE;
            won       <= 1'b0;
            lost      <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            cnt       <= cnt_nx;
            loaded    <= loaded_nx;
            cursor    <= cursor_nx;
            safe_left <= safe_nx;
            mineMap   <= mine_nx;
            flagMap   <= flag_nx;
            stepMap   <= step_nx;
            posMap    <= 64'd1 << cursor_nx;
            won       <= state_nx == S_WON;
            lost      <= state_nx == S_LOST;
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            S_COUNT:  if (loaded && idx == SCAN_LAST) state_nx = (cnt_total == 7'd64) ? S_WON : S_PLAY;
            S_PLAY:   if (step && step_ok) state_nx = mineMap[cursor] ? S_REVEAL : (safe_left == 7'd1 ? S_WON : S_PLAY);
            S_REVEAL: if (idx == SCAN_LAST) state_nx = S_LOST;
            S_LOST, S_WON: if (start) state_nx = S_COUNT;
            default:  state_nx = S_COUNT;
        endcase
    end
    always_comb begin
        idx_nx    = idx;
        cnt_nx    = cnt;
        loaded_nx = loaded;
        cursor_nx = cursor;
        safe_nx   = safe_left;
        mine_nx   = mineMap;
        flag_nx   = flagMap;
        step_nx   = stepMap;
        case (state)
            S_COUNT: begin
                if (!loaded) begin
                    mine_nx   = mine_in;
                    loaded_nx = 1'b1;
                end else begin
                    cnt_nx = cnt_total;
                    idx_nx = (idx == SCAN_LAST) ? 6'd0 : idx + 6'd1;
                    if (idx == SCAN_LAST) begin
                        safe_nx   = 7'd64 - cnt_total;
                        loaded_nx = 1'b0;
                    end
                end
            end
            S_PLAY: begin
                // a step pulse owns the cycle even when the tile refuses it
                if (step) begin
                    if (step_ok) begin
                        step_nx[cursor] = 1'b1;
                        if (mineMap[cursor]) idx_nx = 6'd0;
                        else safe_nx = safe_left - {6'd0, safe_left != 7'd0};
                    end
                end else if (flag) begin
                    if (!stepMap[cursor]) flag_nx[cursor] = ~flagMap[cursor];
                end else if (mv_up) begin
                    cursor_nx = (cursor[5:3] != 3'd0) ? cursor - 6'd8 : cursor;
                end else if (mv_down) begin
                    cursor_nx = (cursor[5:3] != 3'd7) ? cursor + 6'd8 : cursor;
                end else if (mv_left) begin
                    cursor_nx = (cursor[2:0] != 3'd0) ? cursor - 6'd1 : cursor;
                end else if (mv_right) begin
                    cursor_nx = (cursor[2:0] != 3'd7) ? cursor + 6'd1 : cursor;
                end
            end
            S_REVEAL: begin
                if (mineMap[idx]) begin
                    step_nx[idx] = 1'b1;
                    flag_nx[idx] = 1'b0;
                end
                idx_nx = (idx == SCAN_LAST) ? 6'd0 : idx + 6'd1;
            end
            default: begin
                if (start) begin
                    flag_nx   = 64'd0;
                    step_nx   = 64'd0;
                    cursor_nx = START_TILE;
                    idx_nx    = 6'd0;
                    cnt_nx    = 7'd0;
                    loaded_nx = 1'b0;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_minesweeper_game_ctrl.sv
// tb_minesweeper_game_ctrl: vector table, directed corner sequences and random play against a game model
module tb_minesweeper_game_ctrl;
    logic clk = 0, reset = 0, start = 0, mv_up = 0, mv_down = 0, mv_left = 0, mv_right = 0, step = 0, flag = 0;
    logic [63:0] mine_in = 64'd0;
    logic [63:0] mineMap, flagMap, stepMap, posMap;
    logic [2:0]  state;
    logic [6:0]  safe_left;
    logic        won, lost;
    int tests = 0, fails = 0;
    int m_ph, m_t, m_row, m_col, m_safe, mode;
    logic [63:0] m_mine, m_flag, m_step;
    typedef struct packed {
        logic u, d, l, r, f, s;
        logic [5:0] tile;
        logic [63:0] fl, st;
        logic [6:0] safe;
    } vec_t;
    vec_t vq[$];
    always #5 clk = ~clk;
    minesweeper_game_ctrl dut (
        .clk(clk), .reset(reset), .mine_in(mine_in), .start(start),
        .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right),
        .step(step), .flag(flag), .mineMap(mineMap), .flagMap(flagMap), .stepMap(stepMap),
        .posMap(posMap), .state(state), .safe_left(safe_left), .won(won), .lost(lost)
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask
    // game rules: COUNT lasts 65 cycles, REVEAL 64, PLAY one action per cycle
    task automatic model_step();
        int c;
        if (!reset) begin
            m_ph = 0; m_t = 0; m_mine = 0; m_flag = 0; m_step = 0; m_row = 0; m_col = 0; m_safe = 0;
            return;
        end
        c = m_row * 8 + m_col;
        case (m_ph)
            0: begin
                if (m_t == 0) m_mine = mine_in;
                m_t++;
                if (m_t == 65) begin
                    m_safe = 64 - $countones(m_mine);
                    m_ph = (m_safe == 0) ? 4 : 1;
                    m_t = 0;
                end
            end
            1: begin
                if (step) begin
                    if (!m_flag[c] && !m_step[c]) begin
                        m_step[c] = 1'b1;
                        if (m_mine[c]) begin m_ph = 2; m_t = 0; end
                        else begin m_safe--; if (m_safe == 0) m_ph = 4; end
                    end
                end else if (flag) begin
                    if (!m_step[c]) m_flag[c] = ~m_flag[c];
                end else if (mv_up) m_row = (m_row > 0) ? m_row - 1 : 0;
                else if (mv_down) m_row = (m_row < 7) ? m_row + 1 : 7;
                else if (mv_left) m_col = (m_col > 0) ? m_col - 1 : 0;
                else if (mv_right) m_col = (m_col < 7) ? m_col + 1 : 7;
            end
            2: begin
                if (m_mine[m_t]) begin m_step[m_t] = 1'b1; m_flag[m_t] = 1'b0; end
                m_t++;
                if (m_t == 64) begin m_ph = 3; m_t = 0; end
            end
            default: if (start) begin
                m_flag = 0; m_step = 0; m_row = 0; m_col = 0; m_ph = 0; m_t = 0;
            end
        endcase
    endtask
    task automatic check_all();
        chk("state", 64'(state), 64'(m_ph));
        chk("safe_left", 64'(safe_left), 64'(m_safe));
        chk("won", 64'(won), 64'(m_ph == 4));
        chk("lost", 64'(lost), 64'(m_ph == 3));
        chk("mineMap", mineMap, m_mine);
        chk("flagMap", flagMap, m_flag);
        chk("stepMap", stepMap, m_step);
        chk("posMap", posMap, 64'd1 << (m_row * 8 + m_col));
    endtask
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask
    task automatic act(input bit u, d, l, r, f, s, st);
        mv_up = u; mv_down = d; mv_left = l; mv_right = r; flag = f; step = s; start = st;
        cyc();
        {mv_up, mv_down, mv_left, mv_right, flag, step, start} = '0;
    endtask
    task automatic run_count(input int exp_safe, input int exp_state);
        for (int i = 0; i < 65; i++) begin
            cyc();
            if (i < 64) chk("count_state", 64'(state), 64'd0);
        end
        chk("count_exit_state", 64'(state), 64'(exp_state));
        chk("count_safe", 64'(safe_left), 64'(exp_safe));
    endtask
    function automatic vec_t mk(input bit u, d, l, r, f, s, input int tile, input logic [63:0] fl, st, input int safe);
        return '{u: u, d: d, l: l, r: r, f: f, s: s, tile: 6'(tile), fl: fl, st: st, safe: 7'(safe)};
    endfunction
    function automatic logic [63:0] gen_mines(input int md);
        case (md)
            0: return {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            1: return ~((64'd1 << $urandom_range(63)) | (64'd1 << $urandom_range(63)));
            default: return {$urandom, $urandom};
        endcase
    endfunction
    initial begin
        vq.push_back(mk(1,0,0,0,0,0, 0, 0, 0, 63));
        vq.push_back(mk(0,0,1,0,0,0, 0, 0, 0, 63));
        for (int i = 1; i <= 7; i++) vq.push_back(mk(0,0,0,1,0,0, i, 0, 0, 63));
        for (int i = 1; i <= 7; i++) vq.push_back(mk(0,1,0,0,0,0, 7 + 8 * i, 0, 0, 63));
        vq.push_back(mk(0,0,0,1,0,0, 63, 0, 0, 63));
        for (int i = 1; i <= 7; i++) vq.push_back(mk(1,0,0,0,0,0, 63 - 8 * i, 0, 0, 63));
        vq.push_back(mk(0,0,1,0,0,0, 6, 0, 0, 63));
        vq.push_back(mk(0,0,1,0,0,0, 5, 0, 0, 63));
        vq.push_back(mk(0,0,0,0,1,0, 5, 64'h20, 0, 63));
        vq.push_back(mk(0,0,0,0,0,1, 5, 64'h20, 0, 63));
        vq.push_back(mk(0,0,0,0,1,0, 5, 0, 0, 63));
        vq.push_back(mk(0,0,0,0,0,1, 5, 0, 64'h20, 62));
        vq.push_back(mk(0,0,0,0,1,0, 5, 0, 64'h20, 62));
        vq.push_back(mk(0,0,0,1,0,0, 6, 0, 64'h20, 62));
        vq.push_back(mk(0,0,0,1,1,1, 6, 0, 64'h60, 61));
        vq.push_back(mk(0,0,1,1,0,0, 5, 0, 64'h60, 61));
        vq.push_back(mk(1,1,0,0,0,0, 5, 0, 64'h60, 61));
        mine_in = 64'h1;
        cyc(); cyc();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_pos", posMap, 64'h1);
        chk("rst_maps", flagMap | stepMap | mineMap, 64'd0);
        chk("rst_flags", 64'({won, lost}), 64'd0);
        reset = 1;
        run_count(63, 1);
        foreach (vq[i]) begin
            act(vq[i].u, vq[i].d, vq[i].l, vq[i].r, vq[i].f, vq[i].s, 0);
            chk("tbl_pos", posMap, 64'd1 << vq[i].tile);
            chk("tbl_flag", flagMap, vq[i].fl);
            chk("tbl_step", stepMap, vq[i].st);
            chk("tbl_safe", 64'(safe_left), 64'(vq[i].safe));
        end
        mine_in = (64'd1 << 3) | (64'd1 << 40);
        reset = 0; cyc(); reset = 1;
        run_count(62, 1);
        repeat (5) act(0,1,0,0,0,0,0);
        act(0,0,0,0,1,0,0);
        chk("flag40", flagMap, 64'd1 << 40);
        repeat (5) act(1,0,0,0,0,0,0);
        repeat (3) act(0,0,0,1,0,0,0);
        act(0,0,0,0,0,1,0);
        chk("reveal_entry", 64'(state), 64'd2);
        repeat (63) cyc();
        chk("reveal_last", 64'(state), 64'd2);
        cyc();
        chk("lost_state", 64'(state), 64'd3);
        chk("lost_flag", 64'(lost), 64'd1);
        chk("lost_step", stepMap, (64'd1 << 3) | (64'd1 << 40));
        chk("lost_flagmap", flagMap, 64'd0);
        mine_in = ~64'h1;
        act(0,0,0,0,0,0,1);
        chk("restart_state", 64'(state), 64'd0);
        chk("restart_maps", flagMap | stepMap, 64'd0);
        chk("restart_pos", posMap, 64'h1);
        run_count(1, 1);
        act(0,0,0,0,0,1,0);
        chk("win_state", 64'(state), 64'd4);
        chk("win_flag", 64'({won, lost}), 64'b10);
        chk("win_safe", 64'(safe_left), 64'd0);
        mine_in = '1;
        act(0,0,0,0,0,0,1);
        run_count(0, 4);
        chk("allmine_won", 64'(won), 64'd1);
        mine_in = 64'h1;
        act(0,0,0,0,0,0,1);
        run_count(63, 1);
        act(0,0,0,0,0,1,0);
        repeat (10) cyc();
        chk("mid_reveal", 64'(state), 64'd2);
        reset = 0; cyc(); reset = 1;
        chk("rst_mid_state", 64'(state), 64'd0);
        chk("rst_mid_maps", flagMap | stepMap | mineMap, 64'd0);
        mode = 0;
        for (int i = 0; i < 4000; i++) begin
            mv_up = ($urandom_range(3) == 0);
            mv_down = ($urandom_range(3) == 0);
            mv_left = ($urandom_range(3) == 0);
            mv_right = ($urandom_range(3) == 0);
            flag = ($urandom_range(5) == 0);
            step = ($urandom_range(7) == 0);
            start = ($urandom_range(9) == 0);
            reset = ($urandom_range(999) != 0);
            if (start) mode = $urandom_range(2);
            mine_in = gen_mines(mode);
            cyc();
        end
        {mv_up, mv_down, mv_left, mv_right, flag, step, start} = '0;
        reset = 1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
